// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg : shared encodings and types for the pipeline branch predictor
// Rev 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam logic [1:0]  SNT       = 2'd0;
    localparam logic [1:0]  WNT       = 2'd1;
    localparam logic [1:0]  WT        = 2'd2;
    localparam logic [1:0]  ST        = 2'd3;

    localparam logic [31:0] PC_INC    = 32'd4;

    // Widest tag a 32-bit PC can supply above the word offset.
    localparam int          TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 jump;
    } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_branch_predictor_if.sv
// ============================================================================
// pipeline_branch_predictor_if : fetch / decode bus between pipeline and predictor
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipeline_branch_predictor_if #(
    parameter int CNT_W = 16
) ();

    logic [31:0]      if_pc;
    logic             if_hold;
    logic             if_flush;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [31:0]      id_pc;
    logic             id_valid;
    logic             id_is_jump;
    logic             id_stall;
    logic             id_taken;
    logic [31:0]      id_target;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, if_hold, if_flush,
        output id_pc, id_valid, id_is_jump, id_stall, id_taken, id_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, if_hold, if_flush,
        input  id_pc, id_valid, id_is_jump, id_stall, id_taken, id_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
        output stat_branches, stat_mispredicts
    );

endinterface

`default_nettype wire

// File: rtl/bp_btb.sv
// ============================================================================
// bp_btb : direct-mapped BTB, async read (fetch + lookup port), sync write
// Rev 1.0
// ============================================================================
`default_nettype none

module bp_btb
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 16,
    parameter  int TAG_W   = 10,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [IDX_W-1:0] rd_a_idx,
    output btb_entry_t            rd_a,
    input  wire logic [IDX_W-1:0] rd_b_idx,
    output logic                  rd_b_valid,
    output logic [TAG_W-1:0]      rd_b_tag,
    input  wire logic             wr_en,
    input  wire logic [IDX_W-1:0] wr_idx,
    input  wire logic [TAG_W-1:0] wr_tag,
    input  wire logic [31:0]      wr_target,
    input  wire logic             wr_jump
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic               r_jump   [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]    <= wr_tag;
            r_target[wr_idx] <= wr_target;
            r_jump[wr_idx]   <= wr_jump;
        end
    end

    always_comb begin
        rd_a        = '0;
        rd_a.valid  = r_valid[rd_a_idx];
        rd_a.tag    = TAG_MAX_W'(r_tag[rd_a_idx]);
        rd_a.target = r_target[rd_a_idx];
        rd_a.jump   = r_jump[rd_a_idx];
    end

    assign rd_b_valid = r_valid[rd_b_idx];
    assign rd_b_tag   = r_tag[rd_b_idx];

endmodule

`default_nettype wire

// File: rtl/pipeline_branch_predictor.sv
// ============================================================================
// pipeline_branch_predictor : BTB + 2-bit PHT (bimodal/gshare) predictor with ID check
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 10,
    parameter int HIST_W  = 0,
    parameter int CNT_W   = 16
) (
    input  wire logic                  sysclk,
    input  wire logic                  reset,
    pipeline_branch_predictor_if.slave bus
);

    localparam int               IDX_W     = $clog2(ENTRIES);
    localparam int               TAG_LO    = 2 + IDX_W;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [IDX_W-1:0] w_bidx, w_pidx, w_ghr_ext, w_id_bidx;
    logic [TAG_W-1:0] w_if_tag, w_id_tag, w_id_entry_tag;
    btb_entry_t       w_if_entry;
    logic             w_id_entry_valid;
    logic             w_if_hit, w_id_hit, w_pred_taken;
    logic             w_update, w_is_branch, w_mispredict, w_btb_wr;

    logic [1:0]       r_pht [ENTRIES];
    logic             r_p_taken_id;
    logic [31:0]      r_p_target_id;
    logic [IDX_W-1:0] r_pidx_id;
    logic [CNT_W-1:0] r_stat_br, r_stat_mp;

    assign w_bidx    = bus.if_pc[IDX_W+1:2];
    assign w_id_bidx = bus.id_pc[IDX_W+1:2];
    assign w_if_tag  = bus.if_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign w_id_tag  = bus.id_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign w_pidx    = w_bidx ^ w_ghr_ext;

    assign w_update     = bus.id_valid && !bus.id_stall;
    assign w_is_branch  = !bus.id_is_jump;
    assign w_btb_wr     = w_update && bus.id_taken;
    assign w_mispredict = w_update &&
                          ((r_p_taken_id != bus.id_taken) ||
                           (bus.id_taken && (r_p_target_id != bus.id_target)));

    generate
        if (HIST_W == 0) begin : g_bimodal
            assign w_ghr_ext = '0;
        end else begin : g_gshare
            logic [HIST_W-1:0] r_ghr;
            logic [HIST_W-1:0] w_ghr_next;
            if (HIST_W == 1) begin : g_hist1
                assign w_ghr_next = bus.id_taken;
            end else begin : g_histn
                assign w_ghr_next = {r_ghr[HIST_W-2:0], bus.id_taken};
            end
            always_ff @(posedge sysclk or negedge reset) begin
                if (!reset) begin
                    r_ghr <= '0;
                end else if (w_update && w_is_branch) begin
                    r_ghr <= w_ghr_next;
                end
            end
            assign w_ghr_ext = IDX_W'(r_ghr);
        end
    endgenerate

    bp_btb #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk        (sysclk),
        .rst_n      (reset),
        .rd_a_idx   (w_bidx),
        .rd_a       (w_if_entry),
        .rd_b_idx   (w_id_bidx),
        .rd_b_valid (w_id_entry_valid),
        .rd_b_tag   (w_id_entry_tag),
        .wr_en      (w_btb_wr),
        .wr_idx     (w_id_bidx),
        .wr_tag     (w_id_tag),
        .wr_target  (bus.id_target),
        .wr_jump    (bus.id_is_jump)
    );

    assign w_if_hit     = w_if_entry.valid && (w_if_entry.tag == TAG_MAX_W'(w_if_tag));
    assign w_id_hit     = w_id_entry_valid && (w_id_entry_tag == w_id_tag);
    assign w_pred_taken = w_if_hit && (w_if_entry.jump || r_pht[w_pidx][1]);

    // A freshly allocated branch starts weakly taken rather than incrementing.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= WNT;
            end
        end else if (w_update && w_is_branch) begin
            if (bus.id_taken && !w_id_hit) begin
                r_pht[r_pidx_id] <= WT;
            end else if (bus.id_taken) begin
                if (r_pht[r_pidx_id] != ST) r_pht[r_pidx_id] <= r_pht[r_pidx_id] + 2'd1;
            end else begin
                if (r_pht[r_pidx_id] != SNT) r_pht[r_pidx_id] <= r_pht[r_pidx_id] - 2'd1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_p_taken_id  <= 1'b0;
            r_p_target_id <= '0;
            r_pidx_id     <= '0;
        end else if (!bus.if_hold) begin
            if (bus.if_flush) begin
                r_p_taken_id  <= 1'b0;
                r_p_target_id <= '0;
                r_pidx_id     <= '0;
            end else begin
                r_p_taken_id  <= w_pred_taken;
                r_p_target_id <= bus.pred_target;
                r_pidx_id     <= w_pidx;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            if (w_update && (r_stat_br != '1))     r_stat_br <= r_stat_br + c_cnt_one;
            if (w_mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + c_cnt_one;
        end
    end

    assign bus.pred_taken       = w_pred_taken;
    assign bus.pred_target      = w_pred_taken ? w_if_entry.target : bus.if_pc + PC_INC;
    assign bus.mispredict       = w_mispredict;
    assign bus.redirect_pc      = bus.id_taken ? bus.id_target : bus.id_pc + PC_INC;
    assign bus.stat_branches    = r_stat_br;
    assign bus.stat_mispredicts = r_stat_mp;

endmodule

`default_nettype wire
